score_display_ctrl: RTL and testbench
=====================================

// Module: score_display_ctrl
// PURPOSE
//  Parametrised successor of the free-running 4-digit score counter. Holds the game score
//  as a NUM_DIGITS-wide BCD counter (no divide/modulo) and supports increment, decrement,
//  clear and saturation. Time-multiplexes the score onto a common-anode 7-segment display,
//  with optional leading-zero blanking. Sits between the tile-flip game FSM
//  (score_inc/score_dec/score_clr pulses) and the board display pins.
// PARAMETERS
//  NUM_DIGITS           4       BCD digits held and scanned (1..8)
//  DIGIT_PERIOD_CYCLES  131072  clocks each digit stays lit (>=2); 2.6 ms at 50 MHz
//  BLANK_LEADING_ZEROS  1       1: blank zero digits above the most significant nonzero digit
// PORTS
//  clock_50Mhz     in   1             system clock, all logic on rising edge
//  reset           in   1             asynchronous, active-high
//  score_inc       in   1             1-cycle pulse: score +1
//  score_dec       in   1             1-cycle pulse: score -1
//  score_clr       in   1             1-cycle pulse: score := 0, clears overflow
//  score_bcd       out  4*NUM_DIGITS  current score; digit i at [4i+3:4i], digit 0 = LSD
//  overflow        out  1             sticky: an increment was attempted at all-9s
//  Anode_Activate  out  NUM_DIGITS    active-low digit enables; bit i drives digit i
//  LED_out         out  7             active-low cathodes {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (async, active-high):
//   - score_bcd=0, overflow=0.
//   - Anode_Activate=all 1s (all off), LED_out=7'b1111111.
//   - Prescaler=0, scan index=0.
//  Score update (registered; score_bcd changes on the edge after the pulse is sampled high).
//  Priority, per cycle:
//   - score_clr: score=0, overflow=0.
//   - else score_inc & score_dec both high: no change.
//   - else score_inc: BCD +1 with ripple carry (digit 9 -> 0 and carry up).
//     At all 9s: score holds, overflow=1.
//   - else score_dec: BCD -1 with borrow (digit 0 -> 9 and borrow up).
//     At 0: score holds at 0, no flag.
//  Any digit nibble >9 is unreachable; the decoder shows such a nibble as blank.
//  Scan:
//   - Prescaler counts 0..DIGIT_PERIOD_CYCLES-1 and wraps.
//   - On wrap, scan index advances 0,1,..,NUM_DIGITS-1, then back to 0.
//   - Anode_Activate and LED_out are registered from the scan index and the current
//     score_bcd, i.e. one cycle behind the index.
//   - First cycle after reset deasserts: digit 0 is driven.
//   - Exactly one anode bit is low at any time after the first edge following reset.
//  Blanking (BLANK_LEADING_ZEROS=1):
//   - Digit i is blank (LED_out=7'b1111111, anode still low) when i>0 and digits
//     i..NUM_DIGITS-1 are all zero.
//   - Digit 0 always shows, so a score of 0 displays a single "0".
//  Score changes mid-scan are shown from the next registered output; no tearing guard.
//  Segment codes: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000.
// STRUCTURE
//  Shared package: SEG_BLANK and the SEG_0..SEG_9 cathode constants; BCD digit width (4).
//  Sub-module seg7_decoder: combinational 4-bit BCD in + blank in -> 7-bit cathode out.
//   Reused by other display blocks.
//  Score counter, prescaler and scan mux live in this module.
// TESTING (sim with NUM_DIGITS=4, DIGIT_PERIOD_CYCLES=4)
//  1. Assert reset mid-scan -> Anode_Activate=4'b1111, LED_out=7'h7F, score_bcd=0 immediately
//     (async). After release, digit 0 (anode 4'b1110) shows 1000000.
//  2. 9 inc pulses, then 1 more -> score_bcd=16'h0009, then 16'h0010.
//     Display: digit0=1000000, digit1=1111001, digits 2-3 blank.
//  3. Load 9999 via inc pulses, one more inc -> score_bcd stays 16'h9999, overflow=1.
//     score_clr -> 16'h0000, overflow=0.
//  4. From 16'h0100, one dec -> 16'h0099. At 0, dec -> stays 0, overflow stays 0.
//  5. inc and dec in the same cycle -> no change.
//     inc and clr in the same cycle -> score 0.
//  6. Free-run 32 cycles -> anode sequence 1110,1101,1011,0111 repeats, each held 4 cycles,
//     exactly one low bit. With BLANK_LEADING_ZEROS=0 and score 0 -> all digits show 1000000.

Source files
------------

// File: rtl/score_display_ctrl_pkg.sv
// rtl/score_display_ctrl_pkg.sv - shared BCD width and 7-segment cathode constants
package score_display_ctrl_pkg;

    localparam int BCD_W = 4;

    // Active-low cathodes ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD digit to active-low 7-segment cathodes, with blank override
module seg7_decoder
    import score_display_ctrl_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    input  logic             i_blank,
    output logic [6:0]       o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - saturating BCD score counter with multiplexed 7-segment scan
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS          = 4,
    parameter int DIGIT_PERIOD_CYCLES = 131072,
    parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
    input  logic                        clock_50Mhz,
    input  logic                        reset,
    input  logic                        score_inc,
    input  logic                        score_dec,
    input  logic                        score_clr,
    output logic [BCD_W*NUM_DIGITS-1:0] score_bcd,
    output logic                        overflow,
    output logic [NUM_DIGITS-1:0]       Anode_Activate,
    output logic [6:0]                  LED_out
);

    localparam int SCORE_W = BCD_W * NUM_DIGITS;
    localparam int PRESC_W = $clog2(DIGIT_PERIOD_CYCLES);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIGIT_PERIOD_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [SCORE_W-1:0]    r_score;
    logic                  r_overflow;
    logic [PRESC_W-1:0]    r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [6:0]            r_led;

    logic [SCORE_W-1:0]    w_score_inc;
    logic [SCORE_W-1:0]    w_score_dec;
    logic                  w_all_nines;
    logic                  w_is_zero;
    logic                  w_carry;
    logic                  w_borrow;
    logic [BCD_W-1:0]      w_digit;
    logic [BCD_W-1:0]      w_sel_digit;
    logic                  w_sel_blank;
    logic                  w_upper_zero;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_anode_next;

    // Ripple carry/borrow across the BCD digits; no arithmetic beyond single-nibble +-1
    always_comb begin
        w_score_inc = r_score;
        w_score_dec = r_score;
        w_all_nines = 1'b1;
        w_is_zero   = 1'b1;
        w_carry     = 1'b1;
        w_borrow    = 1'b1;
        w_digit     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digit = r_score[i*BCD_W +: BCD_W];
            if (w_digit != 4'd9) w_all_nines = 1'b0;
            if (w_digit != 4'd0) w_is_zero = 1'b0;
            if (w_carry) begin
                if (w_digit == 4'd9) begin
                    w_score_inc[i*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    w_score_inc[i*BCD_W +: BCD_W] = w_digit + 4'd1;
                    w_carry = 1'b0;
                end
            end
            if (w_borrow) begin
                if (w_digit == 4'd0) begin
                    w_score_dec[i*BCD_W +: BCD_W] = 4'd9;
                end else begin
                    w_score_dec[i*BCD_W +: BCD_W] = w_digit - 4'd1;
                    w_borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            r_score    <= '0;
            r_overflow <= 1'b0;
        end else if (score_clr) begin
            r_score    <= '0;
            r_overflow <= 1'b0;
        end else if (score_inc && !score_dec) begin
            if (w_all_nines) r_overflow <= 1'b1;
            else             r_score    <= w_score_inc;
        end else if (score_dec && !score_inc) begin
            if (!w_is_zero) r_score <= w_score_dec;
        end
    end

    // Walk from the top digit down so "all digits at and above i are zero" accumulates
    always_comb begin
        w_sel_digit  = '0;
        w_sel_blank  = 1'b0;
        w_upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (r_score[i*BCD_W +: BCD_W] != 4'd0) w_upper_zero = 1'b0;
            if (IDX_W'(i) == r_idx) begin
                w_sel_digit = r_score[i*BCD_W +: BCD_W];
                w_sel_blank = BLANK_LEADING_ZEROS && (i != 0) && w_upper_zero;
            end
        end
    end

    assign w_anode_next = ~(NUM_DIGITS'(1) << r_idx);

    seg7_decoder u_seg7_decoder (
        .i_digit (w_sel_digit),
        .i_blank (w_sel_blank),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clock_50Mhz or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_anode <= '1;
            r_led   <= SEG_BLANK;
        end else begin
            if (r_presc == PRESC_LAST) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_anode <= w_anode_next;
            r_led   <= w_seg;
        end
    end

    assign score_bcd      = r_score;
    assign overflow       = r_overflow;
    assign Anode_Activate = r_anode;
    assign LED_out        = r_led;

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - randomized self-checking bench against an integer score model
module tb_score_display_ctrl;

    localparam int ND = 4;
    localparam int DP = 4;
    localparam int MAX_SCORE = 9999;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] bcd_a, bcd_b;
    logic        ov_a, ov_b;
    logic [3:0]  an_a, an_b;
    logic [6:0]  led_a, led_b;

    int n_cmp = 0;
    int n_err = 0;
    int m_score = 0;
    bit m_ov = 1'b0;
    int k = 0;

    score_display_ctrl #(.NUM_DIGITS(ND), .DIGIT_PERIOD_CYCLES(DP), .BLANK_LEADING_ZEROS(1'b1)) dut_a (
        .clock_50Mhz    (clk),
        .reset          (rst),
        .score_inc      (inc),
        .score_dec      (dec),
        .score_clr      (clr),
        .score_bcd      (bcd_a),
        .overflow       (ov_a),
        .Anode_Activate (an_a),
        .LED_out        (led_a)
    );

    score_display_ctrl #(.NUM_DIGITS(ND), .DIGIT_PERIOD_CYCLES(DP), .BLANK_LEADING_ZEROS(1'b0)) dut_b (
        .clock_50Mhz    (clk),
        .reset          (rst),
        .score_inc      (inc),
        .score_dec      (dec),
        .score_clr      (clr),
        .score_bcd      (bcd_b),
        .overflow       (ov_b),
        .Anode_Activate (an_b),
        .LED_out        (led_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (k=%0d score=%0d)", tag, got, exp, k, m_score);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'((s / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_led(input int s, input int d, input bit blank_en);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (blank_en && d > 0 && s < p) return 7'h7F;
        return SEG_TAB[(s / p) % 10];
    endfunction

    task automatic step(input bit i_inc, input bit i_dec, input bit i_clr);
        int d;
        int s_before;
        logic [3:0] exp_an;
        inc = i_inc;
        dec = i_dec;
        clr = i_clr;
        @(posedge clk);
        d = (k / DP) % ND;
        s_before = m_score;
        if (i_clr) begin
            m_score = 0;
            m_ov = 1'b0;
        end else if (i_inc && !i_dec) begin
            if (m_score == MAX_SCORE) m_ov = 1'b1;
            else m_score = m_score + 1;
        end else if (i_dec && !i_inc) begin
            if (m_score > 0) m_score = m_score - 1;
        end
        k++;
        exp_an = 4'b1111;
        exp_an[d] = 1'b0;
        @(negedge clk);
        check("score_a", bcd_a, to_bcd(m_score));
        check("ovf_a", ov_a, m_ov);
        check("score_b", bcd_b, to_bcd(m_score));
        check("anode_a", an_a, exp_an);
        check("anode_b", an_b, exp_an);
        check("one_low", $countones(~an_a), 1);
        check("led_a", led_a, exp_led(s_before, d, 1'b1));
        check("led_b", led_b, exp_led(s_before, d, 1'b0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        inc = 1'b0;
        dec = 1'b0;
        clr = 1'b0;
        #1;
        check("rst_score", bcd_a, 16'h0000);
        check("rst_ovf", ov_a, 1'b0);
        check("rst_anode", an_a, 4'hF);
        check("rst_led", led_a, 7'h7F);
        check("rst_anode_b", an_b, 4'hF);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        m_score = 0;
        m_ov = 1'b0;
    endtask

    initial begin
        int r;
        do_reset();
        repeat (7) step(1'b1, 1'b0, 1'b0);
        do_reset();

        repeat (10) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (MAX_SCORE) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        repeat (100) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (32) step(1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)      step(1'b1, 1'b0, 1'b0);
            else if (r < 78) step(1'b0, 1'b1, 1'b0);
            else if (r < 86) step(1'b1, 1'b1, 1'b0);
            else if (r < 89) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            else             step(1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
